// File: rtl/pipelined_adder_stream.sv
// Carry-segmented pipelined adder with a valid/ready stream handshake and full-pipe stall.
// Optional ADDSUB_EN adds an op_sub input that is carried with each beat.
module pipelined_adder_stream #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDSUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = WIDTH / STAGES;

    // Per-stage registers; a/b ride along as skew registers, s holds completed low chunks.
    logic             v_q [STAGES];
    logic             c_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];

    // Stage inputs, taken from the ports for stage 0 and from the previous stage otherwise.
    logic             src_v [STAGES];
    logic             src_c [STAGES];
    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];

    logic             c_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];

`ifdef ADDSUB_EN
    logic sub_q   [STAGES];
    logic src_sub [STAGES];
`endif

    logic stall;

    assign stall     = v_q[STAGES-1] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CW-1:0]    b_chunk;
        logic [CW:0]      part;
        logic [WIDTH-1:0] s_next;

        if (k == 0) begin : g_src_port
            assign src_v[k] = in_valid;
            assign src_c[k] = cin;
            assign src_a[k] = a;
            assign src_b[k] = b;
            assign src_s[k] = '0;
`ifdef ADDSUB_EN
            assign src_sub[k] = op_sub;
`endif
        end else begin : g_src_prev
            assign src_v[k] = v_q[k-1];
            assign src_c[k] = c_q[k-1];
            assign src_a[k] = a_q[k-1];
            assign src_b[k] = b_q[k-1];
            assign src_s[k] = s_q[k-1];
`ifdef ADDSUB_EN
            assign src_sub[k] = sub_q[k-1];
`endif
        end

`ifdef ADDSUB_EN
        assign b_chunk = src_sub[k] ? ~src_b[k][k*CW +: CW] : src_b[k][k*CW +: CW];
`else
        assign b_chunk = src_b[k][k*CW +: CW];
`endif

        assign part = {1'b0, src_a[k][k*CW +: CW]} + {1'b0, b_chunk} + {{CW{1'b0}}, src_c[k]};

        always_comb begin
            s_next = src_s[k];
            s_next[k*CW +: CW] = part[CW-1:0];
        end

        assign s_d[k] = s_next;
        assign c_d[k] = part[CW];
    end

    // Whole pipe advances together; a stalled output freezes every stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                v_q[i] <= 1'b0;
                c_q[i] <= 1'b0;
                a_q[i] <= '0;
                b_q[i] <= '0;
                s_q[i] <= '0;
`ifdef ADDSUB_EN
                sub_q[i] <= 1'b0;
`endif
            end
        end else if (!stall) begin
            for (int i = 0; i < STAGES; i++) begin
                v_q[i] <= src_v[i];
                c_q[i] <= c_d[i];
                a_q[i] <= src_a[i];
                b_q[i] <= src_b[i];
                s_q[i] <= s_d[i];
`ifdef ADDSUB_EN
                sub_q[i] <= src_sub[i];
`endif
            end
        end
    end

endmodule
